// File: rtl/rdma_pkt_queue_pkg.sv
// rdma_pkt_queue_pkg: shared helpers for the RDMA AXI4S queue.
// Widths derive from parameters; no fixed typedefs live here.
package rdma_pkt_queue_pkg;

  function automatic int keep_bits(int data_bits);
    return data_bits / 8;
  endfunction

  function automatic int entry_bits(int data_bits);
    return data_bits + keep_bits(data_bits) + 1;
  endfunction

endpackage

// File: rtl/rdma_pkt_queue_ram.sv
// rdma_pkt_queue_ram: simple dual-port storage, sync write,
// async read, shaped for distributed-RAM inference.
module rdma_pkt_queue_ram #(
  parameter int WIDTH = 577,
  parameter int DEPTH = 32
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // write port: one entry per accepted beat
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/rdma_pkt_queue.sv
// rdma_pkt_queue: parametrised AXI4S queue with optional
// store-and-forward packet mode and flow-control status.
module rdma_pkt_queue
  import rdma_pkt_queue_pkg::*;
#(
  parameter int DATA_BITS = 512,
  parameter int DEPTH     = 32,
  parameter int PKT_MODE  = 1,
  parameter int AF_THRESH = 4
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  input  logic [DATA_BITS-1:0]   s_axis_tdata,
  input  logic [DATA_BITS/8-1:0] s_axis_tkeep,
  input  logic                   s_axis_tlast,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic [DATA_BITS-1:0]   m_axis_tdata,
  output logic [DATA_BITS/8-1:0] m_axis_tkeep,
  output logic                   m_axis_tlast,
  output logic [$clog2(DEPTH):0] occupancy,
  output logic [$clog2(DEPTH):0] pkt_count,
  output logic                   almost_full,
  output logic                   escape
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = entry_bits(DATA_BITS);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] AFT  = (AW+1)'(AF_THRESH);
  localparam logic [AW:0] ONE  = (AW+1)'(1);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   occ;
  logic [AW:0]   occ_next;
  logic [AW:0]   pkts;
  logic [AW:0]   pkts_next;
  logic          esc;
  logic          esc_next;
  logic          af;
  logic          push;
  logic          pop;
  logic          push_last;
  logic          pop_last;
  logic          ready;
  logic          valid;
  logic [EW-1:0] wr_entry;
  logic [EW-1:0] rd_entry;

  assign wr_entry = {s_axis_tlast, s_axis_tkeep, s_axis_tdata};

  rdma_pkt_queue_ram #(
    .WIDTH(EW),
    .DEPTH(DEPTH)
  ) u_ram (
    .clk  (aclk),
    .we   (push),
    .waddr(wr_ptr),
    .wdata(wr_entry),
    .raddr(rd_ptr),
    .rdata(rd_entry)
  );

  assign ready = (occ != FULL);
  assign valid = (occ != '0)
              && ((PKT_MODE == 0) || (pkts != '0) || esc);

  assign push      = s_axis_tvalid & ready;
  assign pop       = valid & m_axis_tready;
  assign push_last = push & s_axis_tlast;
  assign pop_last  = pop & rd_entry[EW-1];

  assign s_axis_tready = ready;
  assign m_axis_tvalid = valid;
  assign {m_axis_tlast, m_axis_tkeep, m_axis_tdata} = rd_entry;
  assign occupancy   = occ;
  assign pkt_count   = pkts;
  assign almost_full = af;
  assign escape      = esc;

  // next-state for counters and the store-and-forward bypass
  always_comb begin
    occ_next  = occ;
    pkts_next = pkts;
    esc_next  = esc;
    unique case ({push, pop})
      2'b10:   occ_next = occ + ONE;
      2'b01:   occ_next = occ - ONE;
      default: occ_next = occ;
    endcase
    unique case ({push_last, pop_last})
      2'b10:   pkts_next = pkts + ONE;
      2'b01:   pkts_next = pkts - ONE;
      default: pkts_next = pkts;
    endcase
    if (PKT_MODE == 0)
      esc_next = 1'b0;
    else if (pop_last)
      esc_next = 1'b0;
    else if (occ == FULL && pkts == '0)
      esc_next = 1'b1;
  end

  // state registers; almost_full tracks next occupancy
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
      pkts   <= '0;
      esc    <= 1'b0;
      af     <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      occ  <= occ_next;
      pkts <= pkts_next;
      esc  <= esc_next;
      af   <= ((FULL - occ_next) <= AFT);
    end
  end

endmodule

// File: tb/tb_rdma_pkt_queue.sv
// tb_rdma_pkt_queue: two queue instances (cut-through and
// store-and-forward) checked against a queue-level model.
module tb_rdma_pkt_queue;

  localparam int DB    = 32;
  localparam int KB    = 4;
  localparam int DEPTH = 32;
  localparam int AF    = 4;
  localparam int MW    = 2048;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          aresetn;
  logic          s_valid;
  logic [DB-1:0] s_data;
  logic [KB-1:0] s_keep;
  logic          s_last;
  logic          m_ready;

  logic          s_ready [2];
  logic          m_valid [2];
  logic [DB-1:0] m_data  [2];
  logic [KB-1:0] m_keep  [2];
  logic          m_last  [2];
  logic [5:0]    occ_o   [2];
  logic [5:0]    pkt_o   [2];
  logic          af_o    [2];
  logic          esc_o   [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    rdma_pkt_queue #(
      .DATA_BITS(DB),
      .DEPTH    (DEPTH),
      .PKT_MODE (g),
      .AF_THRESH(AF)
    ) u_dut (
      .aclk         (clk),
      .aresetn      (aresetn),
      .s_axis_tvalid(s_valid),
      .s_axis_tready(s_ready[g]),
      .s_axis_tdata (s_data),
      .s_axis_tkeep (s_keep),
      .s_axis_tlast (s_last),
      .m_axis_tvalid(m_valid[g]),
      .m_axis_tready(m_ready),
      .m_axis_tdata (m_data[g]),
      .m_axis_tkeep (m_keep[g]),
      .m_axis_tlast (m_last[g]),
      .occupancy    (occ_o[g]),
      .pkt_count    (pkt_o[g]),
      .almost_full  (af_o[g]),
      .escape       (esc_o[g])
    );
  end

  // model: a list of stored beats {last, keep, data} per instance
  logic [36:0] mq [2][MW];
  int  hd [2];
  int  tl [2];
  bit  mesc [2];
  bit  acc [2];
  bit  live;
  int  vectors;
  int  miscompares;

  function automatic int m_occ(int i);
    return tl[i] - hd[i];
  endfunction

  function automatic int m_pkts(int i);
    int n = 0;
    for (int k = hd[i]; k < tl[i]; k++) n += int'(mq[i][k][36]);
    return n;
  endfunction

  function automatic bit m_vld(int i);
    return m_occ(i) != 0 && (i == 0 || m_pkts(i) != 0 || mesc[i]);
  endfunction

  function automatic bit m_rdy(int i);
    return m_occ(i) != DEPTH;
  endfunction

  task automatic chk(string nm, int i, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s[%0d] t=%0t: got %0h expected %0h",
               nm, i, $time, act, exp);
    end
  endtask

  task automatic compare();
    for (int i = 0; i < 2; i++) begin
      chk("s_tready", i, 64'(s_ready[i]), 64'(m_rdy(i)));
      chk("m_tvalid", i, 64'(m_valid[i]), 64'(m_vld(i)));
      chk("occupancy", i, 64'(occ_o[i]), 64'(m_occ(i)));
      chk("pkt_count", i, 64'(pkt_o[i]), 64'(m_pkts(i)));
      chk("almost_full", i, 64'(af_o[i]),
          64'((DEPTH - m_occ(i)) <= AF));
      chk("escape", i, 64'(esc_o[i]), 64'(mesc[i]));
      if (m_vld(i)) begin
        chk("m_tdata", i, 64'(m_data[i]), 64'(mq[i][hd[i]][31:0]));
        chk("m_tkeep", i, 64'(m_keep[i]), 64'(mq[i][hd[i]][35:32]));
        chk("m_tlast", i, 64'(m_last[i]), 64'(mq[i][hd[i]][36]));
      end
    end
  endtask

  task automatic update();
    bit pu;
    bit po;
    bit pl;
    if (!aresetn) begin
      for (int i = 0; i < 2; i++) begin
        hd[i] = 0;
        tl[i] = 0;
        mesc[i] = 1'b0;
        acc[i] = 1'b0;
      end
      live = 1'b1;
    end else if (live) begin
      for (int i = 0; i < 2; i++) begin
        po = m_vld(i) && m_ready;
        pu = s_valid && m_rdy(i);
        pl = po && mq[i][hd[i]][36];
        if (i == 1) begin
          if (pl) mesc[i] = 1'b0;
          else if (m_occ(i) == DEPTH && m_pkts(i) == 0) mesc[i] = 1'b1;
        end
        if (pu) begin
          if (tl[i] >= MW) begin
            $display("FAIL model_overflow[%0d]: got %0d expected <%0d",
                     i, tl[i], MW);
            $fatal(1, "model storage exhausted");
          end
          mq[i][tl[i]] = {s_last, s_keep, s_data};
          tl[i]++;
        end
        if (po) hd[i]++;
        acc[i] = pu;
      end
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    if (live) compare();
    @(posedge clk);
    update();
    #1;
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    s_valid = 1'b0;
    cyc();
    aresetn = 1'b1;
  endtask

  // hold one beat until the store-and-forward instance takes it
  task automatic send_beat(logic [31:0] d, logic l);
    int n = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_keep  = d[3:0] ^ 4'hA;
    s_last  = l;
    do begin
      cyc();
      n++;
    end while (!acc[1] && n < 100);
    chk("push_accept", 1, 64'(acc[1]), 64'd1);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    s_valid = 1'b0;
    m_ready = 1'b1;
    while ((m_occ(0) != 0 || m_occ(1) != 0) && n < 200) begin
      cyc();
      n++;
    end
    chk("drain_occ", 0, 64'(occ_o[0]), 64'd0);
    chk("drain_occ", 1, 64'(occ_o[1]), 64'd0);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    live = 1'b0;
    aresetn = 1'b0;
    s_valid = 1'b0;
    s_data = '0;
    s_keep = '0;
    s_last = 1'b0;
    m_ready = 1'b0;
    cyc();
    cyc();
    aresetn = 1'b1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_tready", i, 64'(s_ready[i]), 64'd1);
      chk("rst_tvalid", i, 64'(m_valid[i]), 64'd0);
      chk("rst_af", i, 64'(af_o[i]), 64'd0);
      chk("rst_occ", i, 64'(occ_o[i]), 64'd0);
    end

    // single beat, visible the cycle after push
    send_beat(32'hA5A5_0001, 1'b1);
    chk("ct_tvalid", 0, 64'(m_valid[0]), 64'd1);
    chk("ct_tdata", 0, 64'(m_data[0]), 64'hA5A5_0001);
    chk("ct_tkeep", 0, 64'(m_keep[0]), 64'hB);
    chk("ct_tlast", 0, 64'(m_last[0]), 64'd1);
    chk("ct_occ", 0, 64'(occ_o[0]), 64'd1);
    chk("sf_pkt", 1, 64'(pkt_o[1]), 64'd1);
    drain();

    // 3-beat packet held until tlast is stored
    m_ready = 1'b1;
    send_beat(32'h100, 1'b0);
    send_beat(32'h101, 1'b0);
    chk("sf_hold_tvalid", 1, 64'(m_valid[1]), 64'd0);
    chk("sf_hold_occ", 1, 64'(occ_o[1]), 64'd2);
    send_beat(32'h102, 1'b1);
    chk("sf_rel_tvalid", 1, 64'(m_valid[1]), 64'd1);
    chk("sf_rel_pkt", 1, 64'(pkt_o[1]), 64'd1);
    chk("sf_rel_data", 1, 64'(m_data[1]), 64'h100);
    cyc();
    cyc();
    cyc();
    chk("sf_done_pkt", 1, 64'(pkt_o[1]), 64'd0);
    drain();

    // fill to DEPTH, then push against a full queue
    do_reset();
    m_ready = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      send_beat(32'h200 + 32'(k), 1'b0);
      if (k == 26) chk("af_27", 1, 64'(af_o[1]), 64'd0);
      if (k == 27) chk("af_28", 1, 64'(af_o[1]), 64'd1);
    end
    chk("full_tready", 0, 64'(s_ready[0]), 64'd0);
    chk("full_tready", 1, 64'(s_ready[1]), 64'd0);
    chk("full_occ", 1, 64'(occ_o[1]), 64'd32);
    m_ready = 1'b1;
    send_beat(32'h300, 1'b1);
    chk("full_swap_occ", 1, 64'(occ_o[1]), 64'd31);
    drain();
    chk("full_esc_clr", 1, 64'(esc_o[1]), 64'd0);

    // 40-beat packet longer than DEPTH needs the escape
    do_reset();
    m_ready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      send_beat(32'h400 + 32'(k), k == 39);
      if (k == 31) begin
        chk("long_occ", 1, 64'(occ_o[1]), 64'd32);
        chk("long_esc_pre", 1, 64'(esc_o[1]), 64'd0);
      end
      if (k == 32) chk("long_esc_set", 1, 64'(esc_o[1]), 64'd1);
    end
    drain();
    chk("long_esc_clr", 1, 64'(esc_o[1]), 64'd0);

    // simultaneous tlast push and tlast pop at occupancy 5
    do_reset();
    m_ready = 1'b0;
    for (int k = 0; k < 5; k++) send_beat(32'h500 + 32'(k), 1'b1);
    m_ready = 1'b1;
    send_beat(32'h600, 1'b1);
    for (int i = 0; i < 2; i++) begin
      chk("swap_occ", i, 64'(occ_o[i]), 64'd5);
      chk("swap_pkt", i, 64'(pkt_o[i]), 64'd5);
    end
    m_ready = 1'b0;

    // reset mid-packet discards everything stored
    do_reset();
    for (int k = 0; k < 10; k++) send_beat(32'h700 + 32'(k), 1'b0);
    chk("mid_occ", 1, 64'(occ_o[1]), 64'd10);
    do_reset();
    for (int i = 0; i < 2; i++) begin
      chk("mid_rst_occ", i, 64'(occ_o[i]), 64'd0);
      chk("mid_rst_pkt", i, 64'(pkt_o[i]), 64'd0);
      chk("mid_rst_tvalid", i, 64'(m_valid[i]), 64'd0);
      chk("mid_rst_tready", i, 64'(s_ready[i]), 64'd1);
    end
    send_beat(32'h800, 1'b0);
    send_beat(32'h801, 1'b1);
    chk("post_rst_data", 1, 64'(m_data[1]), 64'h800);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
